// File: rtl/slc3_bus_pkg.sv
// slc3_bus_pkg: shared types and source indices for the SLC-3 internal bus arbiter.
package slc3_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;
  localparam int N_BUS_SRC = 4;
  localparam int SRC_PC = 0;
  localparam int SRC_MDR = 1;
  localparam int SRC_ALU = 2;
  localparam int SRC_MARMUX = 3;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin winner search starting just after last_ptr.
module rr_priority_picker import slc3_bus_pkg::*; #(
  parameter int N_REQ = N_BUS_SRC,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_ptr,
  output logic             any_req,
  output logic [IW-1:0]    winner
);
  logic [N_REQ-1:0] rot;
  logic [IW-1:0] off;
  always_comb begin
    any_req = |req;
    rot = N_REQ'({req, req} >> (int'(last_ptr) + 1));
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    winner = IW'((int'(last_ptr) + 1 + int'(off)) % N_REQ);
  end
endmodule

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner of the gated internal bus with hold
// timeout and a forced all-zero turnaround gap between owners.
module bus_gate_arbiter import slc3_bus_pkg::*; #(
  parameter int N_REQ = N_BUS_SRC,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYCLES = 1,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gate,
  output logic [IW-1:0]    grant_id,
  output logic             bus_busy,
  output logic             timeout_pulse
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  arb_state_t state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;
  logic [IW-1:0] last_ptr_q, last_ptr_d, grant_id_q, grant_id_d, winner;
  logic [N_REQ-1:0] gate_q, gate_d;
  logic bus_busy_q, bus_busy_d, timeout_q, timeout_d, any_req, pick, hold_hit;
  rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .req(req), .last_ptr(last_ptr_q), .any_req(any_req), .winner(winner)
  );
  assign pick = (state_q == IDLE) || (state_q == TURN && turn_cnt_q == '0);
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD - 1));
  always_comb begin
    state_d = state_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    last_ptr_d = last_ptr_q;
    grant_id_d = grant_id_q;
    gate_d = gate_q;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      if (!req[grant_id_q] || hold_hit) begin
        state_d = TURN;
        gate_d = '0;
        turn_cnt_d = 4'(TURN_CYCLES - 1);
        timeout_d = req[grant_id_q];
      end
    end else if (pick) begin
      state_d = any_req ? GRANT : IDLE;
      if (any_req) begin
        last_ptr_d = winner;
        grant_id_d = winner;
        gate_d = N_REQ'(1) << winner;
        hold_cnt_d = '0;
      end
    end else begin
      turn_cnt_d = turn_cnt_q - 4'd1;
    end
    bus_busy_d = |gate_d;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      last_ptr_q <= IW'(N_REQ - 1);
      grant_id_q <= '0;
      gate_q <= '0;
      bus_busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      last_ptr_q <= last_ptr_d;
      grant_id_q <= grant_id_d;
      gate_q <= gate_d;
      bus_busy_q <= bus_busy_d;
      timeout_q <= timeout_d;
    end
  end
  assign gate = gate_q;
  assign grant_id = grant_id_q;
  assign bus_busy = bus_busy_q;
  assign timeout_pulse = timeout_q;
  a_onehot: assert property (@(posedge Clk) $onehot0(gate_q));
  a_busy: assert property (@(posedge Clk) bus_busy_q == |gate_q);
  a_gap: assert property (@(posedge Clk) disable iff (!Reset_n)
    (gate_q != '0) |=> (gate_q == '0 || $stable(gate_q)));
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// tb_bus_gate_arbiter: directed checks of three arbiter configurations sharing one clock.
module tb_bus_gate_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0] gate_a, gate_b, gate_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic busy_a, busy_b, busy_c, to_a, to_b, to_c;
  int tests = 0;
  int fails = 0;
  int o;
  always #5 clk = ~clk;
  bus_gate_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURN_CYCLES(1)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .req(req_a), .gate(gate_a),
    .grant_id(gid_a), .bus_busy(busy_a), .timeout_pulse(to_a)
  );
  bus_gate_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURN_CYCLES(1)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .req(req_b), .gate(gate_b),
    .grant_id(gid_b), .bus_busy(busy_b), .timeout_pulse(to_b)
  );
  bus_gate_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURN_CYCLES(3)) dut_c (
    .Clk(clk), .Reset_n(rst_n), .req(req_c), .gate(gate_c),
    .grant_id(gid_c), .bus_busy(busy_c), .timeout_pulse(to_c)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    @(negedge clk);
    chk("rst_gate_a", 32'(gate_a), 32'h0);
    chk("rst_gid_a", 32'(gid_a), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_to_a", 32'(to_a), 32'h0);
    chk("rst_gate_b", 32'(gate_b), 32'h0);
    chk("rst_gate_c", 32'(gate_c), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_gate", 32'(gate_a), 32'h0);
      chk("idle_busy", 32'(busy_a), 32'h0);
      chk("idle_to", 32'(to_a), 32'h0);
    end
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("rr_gate k%0d c%0d", k, c), 32'(gate_a), 32'(1 << o));
        chk($sformatf("rr_id k%0d", k), 32'(gid_a), 32'(o));
        chk("rr_busy", 32'(busy_a), 32'h1);
      end
      req_a[o] = 1'b0;
      @(negedge clk);
      chk($sformatf("rr_gap k%0d", k), 32'(gate_a), 32'h0);
      chk("rr_gap_busy", 32'(busy_a), 32'h0);
      req_a[o] = (k < 4);
    end
    req_a = '0;
    @(negedge clk);
    chk("rr_end_idle", 32'(gate_a), 32'h0);
    req_b = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("to_gate c%0d", c), 32'(gate_b), 32'h4);
      chk($sformatf("to_nopulse c%0d", c), 32'(to_b), 32'h0);
      req_b = 4'b0110;
    end
    @(negedge clk);
    chk("to_dead_gate", 32'(gate_b), 32'h0);
    chk("to_pulse", 32'(to_b), 32'h1);
    @(negedge clk);
    chk("to_fair_gate", 32'(gate_b), 32'h2);
    chk("to_fair_id", 32'(gid_b), 32'h1);
    chk("to_pulse_once", 32'(to_b), 32'h0);
    req_b = '0;
    repeat (3) @(negedge clk);
    chk("to_idle", 32'(gate_b), 32'h0);
    req_b = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("race_gate c%0d", c), 32'(gate_b), 32'h8);
    end
    req_b = '0;
    @(negedge clk);
    chk("race_gate_off", 32'(gate_b), 32'h0);
    chk("race_no_pulse", 32'(to_b), 32'h0);
    @(negedge clk);
    chk("race_no_pulse2", 32'(to_b), 32'h0);
    req_c = 4'b0001;
    @(negedge clk);
    chk("turn3_grant", 32'(gate_c), 32'h1);
    req_c = '0;
    @(negedge clk);
    chk("turn3_t0", 32'(gate_c), 32'h0);
    req_c = 4'b1000;
    @(negedge clk);
    chk("turn3_t1", 32'(gate_c), 32'h0);
    req_c = '0;
    @(negedge clk);
    chk("turn3_t2", 32'(gate_c), 32'h0);
    @(negedge clk);
    chk("turn3_no_grant", 32'(gate_c), 32'h0);
    chk("turn3_no_busy", 32'(busy_c), 32'h0);
    req_c = 4'b0100;
    @(negedge clk);
    chk("turn3_idle_lat", 32'(gate_c), 32'h4);
    req_c = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("turn3_gap c%0d", c), 32'(gate_c), 32'h0);
    end
    @(negedge clk);
    chk("turn3_next", 32'(gate_c), 32'h2);
    req_c = '0;
    req_a = 4'b1000;
    @(negedge clk);
    chk("arst_pre", 32'(gate_a), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate", 32'(gate_a), 32'h0);
    chk("arst_busy", 32'(busy_a), 32'h0);
    chk("arst_to", 32'(to_a), 32'h0);
    req_a = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_prio_gate", 32'(gate_a), 32'h1);
    chk("arst_prio_id", 32'(gid_a), 32'h0);
    req_a = 4'b1000;
    @(negedge clk);
    chk("arst_gap", 32'(gate_a), 32'h0);
    @(negedge clk);
    chk("arst_next", 32'(gate_a), 32'h8);
    chk("arst_next_id", 32'(gid_a), 32'h3);
    req_a = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(gate_a), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_gate_arbiter.md
Name: bus_gate_arbiter

Overview:
- Sequences ownership of the SLC-3 internal 16-bit bus between the gated sources: PC, MDR, ALU and MARMUX.
- Drives a registered one-hot gate vector that feeds the bus mux select directly. All-zero selects the default/idle source.
- Arbitration is round-robin, with per-grant hold timeout and an enforced dead (turnaround) interval between owners, so two sources never drive the bus in the same cycle.
- Sits between the control FSM request lines and the bus mux.

Parameters:
- N_REQ, 4, number of requesters. Bit i of req/gate corresponds to bus source i.
- MAX_HOLD, 16, max consecutive GRANT cycles per ownership. 0 disables the timeout.
- TURN_CYCLES, 1, dead cycles with gate all-zero between owners. Legal range 1..15.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  level request per source. Held high for the whole ownership; drop to release.
- gate  output  N_REQ  registered one-hot bus select. All-zero = no driver.
- grant_id  output  $clog2(N_REQ)  binary index of the current owner. Valid only while bus_busy=1.
- bus_busy  output  1  high exactly when gate is non-zero.
- timeout_pulse  output  1  one-cycle pulse when an owner is forcibly released by MAX_HOLD.

Behaviour:
- One clock domain (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset values:
  - gate=0, grant_id=0, bus_busy=0, timeout_pulse=0.
  - state=IDLE, hold_cnt=0, turn_cnt=0.
  - last_ptr=N_REQ-1, so req[0] has top priority after reset.
- Reset mid-grant drops gate to 0 immediately (asynchronously). No pulse is generated.
- All outputs are registered; no combinational path from req to gate.
- Arbitration (pick) is evaluated only in IDLE, or on the final TURN cycle:
  - Winner = first set req bit scanning from (last_ptr+1) mod N_REQ upward, with wrap-around.
  - On a win: last_ptr <= winner, gate <= onehot(winner), grant_id <= winner, hold_cnt <= 0.
- IDLE:
  - No req: stay in IDLE, gate=0.
  - Any req sampled at edge t: GRANT, with gate valid from edge t (visible the cycle after req is first seen high). Latency is 1 cycle.
- GRANT: hold_cnt increments each cycle. Edge checks, in priority order:
  - a) req[owner]=0: go to TURN, gate <= 0, turn_cnt <= TURN_CYCLES-1.
  - b) else MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: go to TURN, gate <= 0, timeout_pulse <= 1 for one cycle.
  - c) else stay; gate unchanged.
  - Release and timeout on the same edge: case a) wins, so no timeout_pulse.
  - Requests from non-owners during GRANT are ignored (no preemption).
- TURN:
  - gate=0 for exactly TURN_CYCLES cycles; turn_cnt counts down.
  - On the edge where turn_cnt==0: pick. Any req goes straight to GRANT (no IDLE cycle); none goes to IDLE.
  - A timed-out owner still holding req competes normally. Because last_ptr=owner, it gets the lowest priority.
- Bus gap invariant: release sampled at edge t gives gate=0 for cycles t..t+TURN_CYCLES-1, and the next gate is set at edge t+TURN_CYCLES.
- A req that is withdrawn before pick is never granted. A req toggled during TURN is sampled only at pick.
- Assertions:
  - $onehot0(gate) always.
  - bus_busy == |gate.
  - gate never changes directly from one non-zero value to a different non-zero value.

Decomposition:
- Package slc3_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t
  - localparam N_BUS_SRC=4
  - source index constants SRC_PC=0, SRC_MDR=1, SRC_ALU=2, SRC_MARMUX=3
- Sub-module rr_priority_picker: combinational.
  - Inputs: req, last_ptr.
  - Outputs: any_req, winner index.
  - Implementation: double-width rotate-and-priority-encode.
- FSM, counters and output registers live in bus_gate_arbiter.

Test Plan:
- Reset release, req=4'b0000 for 5 cycles -> gate=0, bus_busy=0 throughout, timeout_pulse never asserts.
- req=4'b1111 held, each owner drops req after 3 GRANT cycles, TURN_CYCLES=1 -> grant order 0,1,2,3,0, each gate high 3 cycles, separated by exactly 1 zero cycle.
- req[2] held high continuously with MAX_HOLD=4 and req[1] high -> gate=4'b0100 for 4 cycles, timeout_pulse=1 once, 1 dead cycle, then gate=4'b0010 (fairness after timeout).
- Owner drops req on the same edge hold_cnt hits MAX_HOLD-1 -> TURN entered, timeout_pulse stays 0.
- Reset_n pulled low mid-GRANT (gate=4'b1000) between clock edges -> gate=0 immediately. After release, req=4'b1001 grants index 0 first.
- TURN_CYCLES=3, req[3] asserted and dropped during TURN -> no grant to 3, FSM returns to IDLE, gate stays 0.
